rr_arb3_reg: RTL
================

Name: rr_arb3_reg

Overview:
- Three-input round-robin arbiter with a one-entry registered output stage.
- Arbitrates among three valid/ready source channels.
- Drives a 2-bit select `s` whose encoding matches the team's 3:1 mux convention: 00→d0, 01→d1, 10→d2.
- Captures the granted word into an output register with valid/ready handshake. Sits at the head of the shared 8-bit datapath and feeds the downstream consumer.

Parameters:
- WIDTH, 8, data width of each source and of the output.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- d0  input  WIDTH  source 0 data.
- d1  input  WIDTH  source 1 data.
- d2  input  WIDTH  source 2 data.
- v  input  3  per-source valid; v[i] belongs to di.
- rdy  output  3  per-source ready; combinational.
- s  output  2  current grant select (00/01/10; 11 never driven); combinational.
- y  output  WIDTH  registered output data.
- y_valid  output  1  registered; y holds an untaken word.
- y_ready  input  1  downstream accepts y this cycle.
- last  output  2  registered index of the most recently transferred source.

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, independent of clk):
  - y = 0, y_valid = 0, last = 2'b10 (so source 0 has first priority).
  - s and rdy follow from these values: rdy = 000 whenever v = 000.
- Reset asserted mid-transfer: the in-flight word is discarded, nothing is retained.
- Output slot free: ofree = !y_valid || y_ready.
- Priority order, rotating from last:
  - last=00 → 1,2,0
  - last=01 → 2,0,1
  - last=10 → 0,1,2
- Grant g = first index in the priority order with v[g]=1.
- s = g when any v is set; otherwise s = last, so the select is stable when idle.
- rdy[i] = (i == g) && (v != 0) && ofree. At most one rdy bit is set per cycle. Sources must not depend on rdy to assert v.
- Transfer from source i: v[i] && rdy[i] at a rising edge. On that edge:
  - y ← di
  - y_valid ← 1
  - last ← i
- Output pop: y_valid && y_ready at a rising edge.
  - Pop with no transfer on the same edge: y_valid ← 0; y keeps its old value.
- Simultaneous pop and transfer on the same edge:
  - The new word loads and y_valid stays 1, giving full throughput of 1 word/cycle.
- Backpressure (y_valid && !y_ready):
  - rdy = 000; y, y_valid and last hold.
  - s still tracks g combinationally; the grant is not locked.
- Latency: 1 cycle from a source transfer to y_valid/y.
- Fairness: with all three v continuously high and y_ready=1, grants cycle 0,1,2,0,… with no source starved more than 2 cycles.
- A source may drop v without a transfer. The pointer does not move without a transfer.
- Arithmetic: none. Pointer advance is a mod-3 rotation; value 11 is illegal and unreachable.
- y is never X after reset; y is only loaded from the granted source.

Test Plan:
- Reset, then v=000, y_ready=1 → rdy=000, y_valid=0, y=0, s=10, last=10.
- v=111, d0=8'h11, d1=8'h22, d2=8'h33, y_ready=1 for 6 cycles → y sequence 11,22,33,11,22,33; y_valid=1 from cycle 1; last cycles 00,01,10.
- Backpressure: load d1=8'hA5, then y_ready=0 for 3 cycles with v=101 → y=A5 held, y_valid=1, rdy=000; release y_ready → next grant is source 2 (s=10), then source 0.
- Single requester: only v[1]=1 for 4 cycles, y_ready=1 → 4 consecutive transfers from d1, last=01 throughout, no bubble.
- Pop with no source: y_valid=1, v=000, y_ready=1 → y_valid=0 next cycle, y keeps old value, s=last.
- Asynchronous reset asserted between clock edges while y_valid=1 and v=111 → y_valid=0, y=0, last=10 immediately, without waiting for a clk edge; first grant after release goes to source 0.

Source files
------------

// File: rtl/rr_arb3_reg.sv
// rr_arb3_reg: three-source round-robin arbiter feeding a one-entry registered output stage
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   d0, d1, d2, v    source data words and per-source valid bits
//   rdy              per-source ready, combinational, at most one bit set
//   s                grant select (00 -> d0, 01 -> d1, 10 -> d2)
//   y, y_valid       registered output word and its valid flag
//   y_ready          downstream accepts y this cycle
//   last             index of the most recently transferred source
module rr_arb3_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [2:0]       v,
  output logic [2:0]       rdy,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [1:0]       last
);
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       p0, p1, g;
  logic             ofree, xfer;
  logic [WIDTH-1:0] dsel;
  always_comb begin
    // priority rotates so the source after last is checked first, last itself least
    p0 = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    p1 = (p0 == 2'd2) ? 2'd0 : p0 + 2'd1;
    g = v[p0] ? p0 : v[p1] ? p1 : last_q;
    s = (|v) ? g : last_q;
    ofree = !y_valid_q || y_ready;
    rdy = ((|v) && ofree) ? (3'b001 << g) : 3'b000;
    xfer = |rdy;
    dsel = (s == 2'd0) ? d0 : (s == 2'd1) ? d1 : d2;
    y_d = xfer ? dsel : y_q;
    last_d = xfer ? g : last_q;
    y_valid_d = xfer || (y_valid_q && !y_ready);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      last_q    <= 2'd2;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      last_q    <= last_d;
    end
  end
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign last    = last_q;
endmodule
